// File: rtl/procyon_ccu_arb_pkg.sv
// Shared CCU length codes, arbiter state encoding and index-width helper.
// The `PCYN_* macros are guarded so they coexist with procyon_constants.svh.
`ifndef PCYN_CCU_LEN_WIDTH
`define PCYN_CCU_LEN_WIDTH 3
`define PCYN_CCU_LEN_1B    3'b000
`define PCYN_CCU_LEN_2B    3'b001
`define PCYN_CCU_LEN_4B    3'b010
`define PCYN_CCU_LEN_8B    3'b011
`define PCYN_CCU_LEN_16B   3'b100
`define PCYN_CCU_LEN_32B   3'b101
`endif

`ifndef PCYN_CCU_ARB_STATE_WIDTH
`define PCYN_CCU_ARB_STATE_WIDTH 2
`define PCYN_CCU_ARB_STATE_IDLE  2'b00
`define PCYN_CCU_ARB_STATE_BUSY  2'b01
`define PCYN_CCU_ARB_STATE_DONE  2'b10
`endif

package procyon_ccu_arb_pkg;

   localparam int CCU_LEN_WIDTH = `PCYN_CCU_LEN_WIDTH;
   localparam logic [CCU_LEN_WIDTH-1:0] CCU_LEN_32B = `PCYN_CCU_LEN_32B;

   localparam logic [1:0] ARB_IDLE = `PCYN_CCU_ARB_STATE_IDLE;
   localparam logic [1:0] ARB_BUSY = `PCYN_CCU_ARB_STATE_BUSY;
   localparam logic [1:0] ARB_DONE = `PCYN_CCU_ARB_STATE_DONE;

   // A single requester still needs a 1-bit index.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/procyon_ccu_arb_picker.sv
// Combinational winner picker: round-robin from ptr with PCYN_CCU_ARB_RR_EN, else lowest index wins.
// Zero latency, no handshake; the caller samples the result only while idle.
module procyon_ccu_arb_picker #(
   parameter int REQ_NUM   = 2,
   parameter int IDX_WIDTH = 1
) (
   input  logic [REQ_NUM-1:0]   req,
   input  logic [IDX_WIDTH-1:0] ptr,
   output logic [REQ_NUM-1:0]   onehot,
   output logic [IDX_WIDTH-1:0] idx
);

   logic [IDX_WIDTH-1:0] start;
   logic [IDX_WIDTH-1:0] pos;
   logic                 found;

`ifdef PCYN_CCU_ARB_RR_EN
   assign start = ptr;
`else
   logic unused_ptr;
   assign unused_ptr = ^ptr;
   assign start      = '0;
`endif

   // Walk the requests starting at 'start', wrapping at REQ_NUM-1.
   always_comb begin
      onehot = '0;
      found  = 1'b0;
      pos    = start;
      for (int k = 0; k < REQ_NUM; k++) begin
         if (!found && req[pos]) begin
            onehot[pos] = 1'b1;
            found       = 1'b1;
         end
         pos = (pos == IDX_WIDTH'(REQ_NUM - 1)) ? '0 : pos + IDX_WIDTH'(1);
      end
   end

   procyon_onehot2binary #(
      .OPTN_ONEHOT_WIDTH (REQ_NUM),
      .OPTN_BINARY_WIDTH (IDX_WIDTH)
   ) u_onehot2binary (
      .i_onehot (onehot),
      .o_binary (idx)
   );

endmodule

// File: rtl/procyon_onehot2binary.sv
// One-hot to binary index encoder; purely combinational, no handshake.
module procyon_onehot2binary #(
   parameter int OPTN_ONEHOT_WIDTH = 2,
   parameter int OPTN_BINARY_WIDTH = 1
) (
   input  logic [OPTN_ONEHOT_WIDTH-1:0] i_onehot,
   output logic [OPTN_BINARY_WIDTH-1:0] o_binary
);

   always_comb begin
      o_binary = '0;
      for (int i = 0; i < OPTN_ONEHOT_WIDTH; i++) begin
         if (i_onehot[i]) o_binary = o_binary | OPTN_BINARY_WIDTH'(i);
      end
   end

endmodule

// File: rtl/procyon_ccu_arb.sv
// Shares the single BIF between CCU requesters (round-robin when PCYN_CCU_ARB_RR_EN is defined).
// bif_en 1 cycle after a request is seen; grant pulses 1 cycle after bif_done; requesters hold until granted.
module procyon_ccu_arb
   import procyon_ccu_arb_pkg::*;
#(
   parameter int OPTN_ADDR_WIDTH   = 32,
   parameter int OPTN_DC_LINE_SIZE = 32,
   parameter int OPTN_CCU_REQ_NUM  = 2,
   parameter int DC_LINE_WIDTH     = OPTN_DC_LINE_SIZE * 8
) (
   input  logic                        clk,
   input  logic                        n_rst,
   input  logic [OPTN_CCU_REQ_NUM-1:0] i_ccu_en,
   input  logic [OPTN_CCU_REQ_NUM-1:0] i_ccu_we,
   input  logic [CCU_LEN_WIDTH-1:0]    i_ccu_len  [0:OPTN_CCU_REQ_NUM-1],
   input  logic [OPTN_ADDR_WIDTH-1:0]  i_ccu_addr [0:OPTN_CCU_REQ_NUM-1],
   input  logic [DC_LINE_WIDTH-1:0]    i_ccu_data [0:OPTN_CCU_REQ_NUM-1],
   output logic [OPTN_CCU_REQ_NUM-1:0] o_ccu_grant,
   output logic [DC_LINE_WIDTH-1:0]    o_ccu_data,
   output logic                        o_bif_en,
   output logic                        o_bif_we,
   output logic [CCU_LEN_WIDTH-1:0]    o_bif_len,
   output logic [OPTN_ADDR_WIDTH-1:0]  o_bif_addr,
   output logic [DC_LINE_WIDTH-1:0]    o_bif_data,
   input  logic                        i_bif_done,
   input  logic [DC_LINE_WIDTH-1:0]    i_bif_data
);

   localparam int IW = idx_width(OPTN_CCU_REQ_NUM);

   logic [1:0]                  state;
   logic [OPTN_CCU_REQ_NUM-1:0] pick_onehot;
   logic [IW-1:0]               pick_idx;
   logic [IW-1:0]               ptr;
   logic [OPTN_CCU_REQ_NUM-1:0] sel;
   logic                        we_q;
   logic [CCU_LEN_WIDTH-1:0]    len_q;
   logic [OPTN_ADDR_WIDTH-1:0]  addr_q;
   logic [DC_LINE_WIDTH-1:0]    data_q;

   procyon_ccu_arb_picker #(
      .REQ_NUM   (OPTN_CCU_REQ_NUM),
      .IDX_WIDTH (IW)
   ) u_picker (
      .req    (i_ccu_en),
      .ptr    (ptr),
      .onehot (pick_onehot),
      .idx    (pick_idx)
   );

   // data_q doubles as write data towards the BIF and read data back to the requester.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state  <= ARB_IDLE;
         sel    <= '0;
         we_q   <= 1'b0;
         len_q  <= '0;
         addr_q <= '0;
         data_q <= '0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (|i_ccu_en) begin
                  state  <= ARB_BUSY;
                  sel    <= pick_onehot;
                  we_q   <= i_ccu_we[pick_idx];
                  len_q  <= i_ccu_len[pick_idx];
                  addr_q <= i_ccu_addr[pick_idx];
                  data_q <= i_ccu_data[pick_idx];
               end
            end
            ARB_BUSY: begin
               if (i_bif_done) begin
                  state <= ARB_DONE;
                  if (!we_q) data_q <= i_bif_data;
               end
            end
            ARB_DONE: state <= ARB_IDLE;
            default:  state <= ARB_IDLE;
         endcase
      end
   end

`ifdef PCYN_CCU_ARB_RR_EN
   logic [IW-1:0] winner;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         winner <= '0;
         ptr    <= '0;
      end else begin
         if (state == ARB_IDLE && |i_ccu_en) winner <= pick_idx;
         if (state == ARB_DONE) begin
            ptr <= (winner == IW'(OPTN_CCU_REQ_NUM - 1)) ? '0 : winner + IW'(1);
         end
      end
   end
`else
   assign ptr = '0;
`endif

   // Outputs decode straight from state so reset drops bif_en without waiting for a clock.
   assign o_bif_en    = (state == ARB_BUSY);
   assign o_ccu_grant = (state == ARB_DONE) ? sel : '0;
   assign o_ccu_data  = data_q;
   assign o_bif_we    = we_q;
   assign o_bif_len   = len_q;
   assign o_bif_addr  = addr_q;
   assign o_bif_data  = data_q;

endmodule
